// File: rtl/core_pkg.sv
// core_pkg: memory-map constants, access-width enum and load alignment shared by the LSU and TCMs
package core_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11} mem_width_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} dtcm_state_t;
    localparam logic [31:0] ITCM_BASE = 32'h0000_0000;
    localparam logic [31:0] ITCM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DTCM_BASE = 32'h0000_1000;
    localparam logic [31:0] DTCM_SIZE = 32'h0000_4000;
    localparam logic [31:0] CSR_BASE  = 32'hF000_0000;
    localparam logic [31:0] CSR_SIZE  = 32'h0000_1000;
    function automatic logic [31:0] load_align(input logic [31:0] word, input mem_width_t width,
                                               input logic [1:0] lane, input logic sext);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        return width == BYTE ? {{24{sext & sh[7]}}, sh[7:0]} :
               width == HALF ? {{16{sext & sh[15]}}, sh[15:0]} : word;
    endfunction
endpackage

// File: rtl/dtcm_ram.sv
// dtcm_ram: single-port synchronous RAM, 32-bit words, per-byte write enables, 1-cycle read
module dtcm_ram #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata_q <= mem[addr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/data_tcm_ctrl.sv
// data_tcm_ctrl: LSU-facing data TCM controller with fault checking and load alignment
module data_tcm_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DTCM_BASE,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_sign_extend,
    input  logic [1:0]  req_data_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTES = 32'(4 * DEPTH_WORDS);
    dtcm_state_t state_q, state_d;
    mem_width_t  width, width_q, width_d;
    logic [1:0]  lane_q, lane_d;
    logic        sign_q, sign_d, err_q, err_d, accept, fault;
    logic [31:0] rdata_q, rdata_d, off, ram_rdata, wdata;
    logic [3:0]  be, ram_we;
    dtcm_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
        .clk(clk), .we(ram_we), .addr(off[AW+1:2]), .wdata(wdata), .rdata(ram_rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        width_q <= width_d;
        lane_q  <= lane_d;
        sign_q  <= sign_d;
    end
    // Below-base addresses wrap to huge offsets, so one compare covers both window edges
    always_comb begin
        width   = mem_width_t'(req_data_width);
        off     = req_addr - BASE_ADDR;
        accept  = req_valid && state_q == S_IDLE;
        fault   = width == RSVD || (width == HALF && req_addr[0]) ||
                  (width == WORD && req_addr[1:0] != 2'b00) || off >= BYTES;
        state_d = state_q == S_IDLE ? (req_valid ? ((req_we || fault) ? S_RESP : S_READ) : S_IDLE) :
                  state_q == S_READ ? S_RESP : (rsp_ready ? S_IDLE : S_RESP);
        rdata_d = accept ? '0 :
                  state_q == S_READ ? load_align(ram_rdata, width_q, lane_q, sign_q) : rdata_q;
        err_d   = accept ? fault : err_q;
        width_d = accept ? width : width_q;
        lane_d  = accept ? req_addr[1:0] : lane_q;
        sign_d  = accept ? req_sign_extend : sign_q;
    end
    always_comb begin
        req_ready = state_q == S_IDLE;
        rsp_valid = state_q == S_RESP;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        be        = width == BYTE ? 4'b0001 << req_addr[1:0] :
                    width == HALF ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata     = width == BYTE ? {4{req_wdata[7:0]}} :
                    width == HALF ? {2{req_wdata[15:0]}} : req_wdata;
        ram_we    = (accept && req_we && !fault && !rst) ? be : 4'b0000;
    end
endmodule

// File: tb/tb_data_tcm_ctrl.sv
// tb_data_tcm_ctrl: directed self-checking bench for data_tcm_ctrl
module tb_data_tcm_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_sign_extend = 1'b0;
    logic [1:0]  req_data_width = 2'b10;
    logic [31:0] req_addr = 32'h1000, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;
    int          n_chk = 0, n_err = 0, lat;
    logic [31:0] rd;
    logic        er;

    data_tcm_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sign_extend(req_sign_extend), .req_data_width(req_data_width), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request, scrambles req_* after accept, waits for the response and consumes it
    task automatic xact(input logic we, input logic sx, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, output int l, output logic [31:0] r, output logic e);
        req_valid = 1'b1; req_we = we; req_sign_extend = sx; req_data_width = w;
        req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0; req_we = 1'b0; req_sign_extend = ~sx; req_data_width = 2'b11;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
        l = 1;
        while (!rsp_valid && l < 8) begin
            tick;
            l++;
        end
        r = rsp_rdata;
        e = rsp_err;
        tick;
    endtask

    initial begin
        tick; tick;
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        xact(1, 0, 2'b10, 32'h1000, 32'hDEAD_BEEF, lat, rd, er);
        chk("st_word_lat", 32'(lat), 32'd1);
        chk("st_word_rdata", rd, 32'd0);
        chk("st_word_err", 32'(er), 32'd0);
        xact(0, 0, 2'b10, 32'h1000, 32'h0, lat, rd, er);
        chk("ld_word_lat", 32'(lat), 32'd2);
        chk("ld_word_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_word_err", 32'(er), 32'd0);

        xact(1, 0, 2'b10, 32'h1000, 32'h0, lat, rd, er);
        xact(1, 0, 2'b00, 32'h1003, 32'hFFFF_FF80, lat, rd, er);
        xact(0, 1, 2'b00, 32'h1003, 32'h0, lat, rd, er);
        chk("ld_byte_signed", rd, 32'hFFFF_FF80);
        xact(0, 0, 2'b00, 32'h1003, 32'h0, lat, rd, er);
        chk("ld_byte_unsigned", rd, 32'h0000_0080);
        xact(0, 0, 2'b10, 32'h1000, 32'h0, lat, rd, er);
        chk("ld_word_after_byte", rd, 32'h8000_0000);

        xact(0, 0, 2'b01, 32'h1001, 32'h0, lat, rd, er);
        chk("mis_half_err", 32'(er), 32'd1);
        chk("mis_half_rdata", rd, 32'd0);
        chk("mis_half_lat", 32'(lat), 32'd1);
        xact(1, 0, 2'b10, 32'h5000, 32'h1234_5678, lat, rd, er);
        chk("oow_store_err", 32'(er), 32'd1);
        xact(0, 0, 2'b10, 32'h0FFC, 32'h0, lat, rd, er);
        chk("below_base_err", 32'(er), 32'd1);
        xact(0, 0, 2'b11, 32'h1000, 32'h0, lat, rd, er);
        chk("rsvd_width_err", 32'(er), 32'd1);
        xact(1, 0, 2'b10, 32'h1002, 32'h1111_1111, lat, rd, er);
        chk("mis_word_store_err", 32'(er), 32'd1);
        xact(0, 0, 2'b10, 32'h1000, 32'h0, lat, rd, er);
        chk("ram_unchanged", rd, 32'h8000_0000);

        xact(1, 0, 2'b10, 32'h1004, 32'h1234_8765, lat, rd, er);
        xact(0, 1, 2'b01, 32'h1006, 32'h0, lat, rd, er);
        chk("ld_half_hi_signed", rd, 32'h0000_1234);
        xact(0, 1, 2'b01, 32'h1004, 32'h0, lat, rd, er);
        chk("ld_half_lo_signed", rd, 32'hFFFF_8765);
        xact(1, 0, 2'b01, 32'h1006, 32'hFFFF_ABCD, lat, rd, er);
        xact(0, 0, 2'b10, 32'h1004, 32'h0, lat, rd, er);
        chk("st_half_merge", rd, 32'hABCD_8765);

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_data_width = 2'b10; req_addr = 32'h1004;
        tick;
        req_valid = 1'b0; req_addr = 32'h1000;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hABCD_8765);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("hold_release_ready", 32'(req_ready), 32'd1);
        chk("hold_release_valid", 32'(rsp_valid), 32'd0);

        req_valid = 1'b1; req_we = 1'b0; req_data_width = 2'b10; req_addr = 32'h1000;
        tick;
        req_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_read_valid", 32'(rsp_valid), 32'd0);
        chk("rst_read_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_read_no_rsp", 32'(rsp_valid), 32'd0);
        end

        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_data_width = 2'b10; req_addr = 32'h1000;
        req_wdata = 32'h5555_5555;
        tick;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        xact(0, 0, 2'b10, 32'h1000, 32'h0, lat, rd, er);
        chk("rst_store_no_write", rd, 32'h8000_0000);

        xact(1, 0, 2'b00, 32'h4FFC, 32'h11, lat, rd, er);
        xact(1, 0, 2'b00, 32'h4FFD, 32'h22, lat, rd, er);
        xact(1, 0, 2'b00, 32'h4FFE, 32'h33, lat, rd, er);
        xact(1, 0, 2'b00, 32'h4FFF, 32'h44, lat, rd, er);
        chk("top_byte_err", 32'(er), 32'd0);
        xact(0, 0, 2'b10, 32'h4FFC, 32'h0, lat, rd, er);
        chk("top_word_rdata", rd, 32'h4433_2211);
        chk("top_word_err", 32'(er), 32'd0);
        xact(0, 0, 2'b00, 32'h4FFE, 32'h0, lat, rd, er);
        chk("top_byte_lane2", rd, 32'h0000_0033);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
